// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the request/response handshake to
// instruction memory and fills the IF/ID register that feeds decode.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic        load_en;
  logic [31:0] load_word;
  logic [31:0] tgt;

  assign tgt       = redirect_target & ~32'h3;
  assign imem_req  = (state_q == S_FETCH) & ~redirect & reset;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    hold_buf_d = hold_buf_q;
    load_en    = 1'b0;
    load_word  = imem_rdata;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d = tgt;
        end else begin
          fetch_pc_d = pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = tgt;
          state_d = imem_rvalid ? S_FETCH : S_DISCARD;
        end else if (imem_rvalid && !stall) begin
          load_en = 1'b1;
          pc_d    = fetch_pc_q + 32'd4;
          state_d = S_FETCH;
        end else if (imem_rvalid) begin
          hold_buf_d = imem_rdata;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d       = tgt;
          hold_buf_d = '0;
          state_d    = S_FETCH;
        end else if (!stall) begin
          load_en   = 1'b1;
          load_word = hold_buf_q;
          pc_d      = fetch_pc_q + 32'd4;
          state_d   = S_FETCH;
        end
      end
      default: begin
        // A response landing together with a fresh redirect still retires the
        // stale request, otherwise DISCARD would wait forever.
        if (redirect) begin
          pc_d    = tgt;
          state_d = imem_rvalid ? S_FETCH : S_DISCARD;
        end else if (imem_rvalid) begin
          state_d = S_FETCH;
        end
      end
    endcase
  end

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= '0;
      hold_buf_q  <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      hold_buf_q <= hold_buf_d;
      if (redirect) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (!stall) begin
        if (load_en) begin
          if_id_valid <= 1'b1;
          if_id_instr <= load_word;
          if_id_pc    <= fetch_pc_q;
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: variable-latency memory model plus a transaction-level
// reference of the fetch stage, driven by directed and random stimulus.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_rvalid;
  logic [31:0] redirect_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, pc_out, if_id_pc, if_id_instr;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // memory: at most one request in flight, answered after lat cycles
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  // reference: fetch in flight (and whether killed), one fetched word waiting
  bit          m_out, m_kill, m_have, m_valid;
  logic [31:0] m_pc, m_word, m_faddr, m_instr, m_idpc;

  task automatic model_reset();
    m_pc = RESET_PC; m_out = 0; m_kill = 0; m_have = 0;
    m_valid = 0; m_instr = NOP; m_idpc = '0; m_faddr = '0; m_word = '0;
  endtask

  task automatic cycle(input bit rst_v, input bit st, input bit rd,
                       input logic [31:0] tgt, input bit spur);
    bit er, got;
    reset = rst_v; stall = st; redirect = rd; redirect_target = tgt;
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    if (!rst_v) begin
      mem_busy = 0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr); mem_busy = 0;
      end
    end
    if (spur) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    end
    er = rst_v && !rd && !m_out && !m_have;
    @(negedge clk);
    check("imem_req", {31'b0, imem_req}, {31'b0, er});
    check("imem_addr", imem_addr, m_pc);
    if (imem_req) begin
      mem_busy = 1; mem_addr = imem_addr; mem_cnt = lat;
    end
    if (!rst_v) begin
      model_reset();
    end else begin
      got = imem_rvalid && m_out;
      if (rd) begin
        m_pc = tgt & ~32'h3;
        m_have = 0;
        if (m_out && !got) m_kill = 1;
        else begin m_out = 0; m_kill = 0; end
        m_valid = 0; m_instr = NOP;
      end else begin
        if (got) begin
          m_out = 0;
          if (m_kill) m_kill = 0;
          else begin m_have = 1; m_word = imem_rdata; end
        end
        if (m_have && !st) begin
          m_valid = 1; m_instr = m_word; m_idpc = m_faddr;
          m_pc = m_faddr + 32'd4; m_have = 0;
        end else if (!st) begin
          m_valid = 0; m_instr = NOP;
        end
        if (er) begin m_out = 1; m_faddr = m_pc; end
      end
    end
    @(posedge clk); #1;
    check("pc_out", pc_out, m_pc);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc", if_id_pc, m_idpc);
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 32'h0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    reset = 0; stall = 0; redirect = 0; redirect_target = '0;
    imem_rvalid = 0; imem_rdata = '0; mem_busy = 0; mem_addr = '0; mem_cnt = 0;
    model_reset();
    @(posedge clk); #1;

    // reset state, then sequential fetch with a 3-cycle stall over word@8
    do_reset(3);
    check("rst_pc", pc_out, RESET_PC);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_idpc", if_id_pc, 32'h0);
    lat = 1;
    run_free(5);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 32'h0, 0);
    check("stall_idpc", if_id_pc, 32'h4);
    run_free(1);
    check("unstall_idpc", if_id_pc, 32'h8);
    check("unstall_pc", pc_out, 32'hC);
    run_free(6);

    // redirect while waiting on a 3-cycle memory
    do_reset(2);
    lat = 3;
    run_free(1);
    cycle(1, 0, 1, 32'h100, 0);
    check("redir_pc", pc_out, 32'h100);
    run_free(12);

    // redirect and stall together: flush wins
    cycle(1, 1, 1, 32'h200, 0);
    check("flush_valid", {31'b0, if_id_valid}, 32'h0);
    check("flush_pc", pc_out, 32'h200);
    run_free(8);

    // wrap at the top of the address space (low target bits ignored)
    lat = 1;
    cycle(1, 0, 1, 32'hFFFF_FFFE, 0);
    run_free(6);

    // reset mid-WAIT with a late response in the first cycle after release
    do_reset(1);
    lat = 3;
    run_free(1);
    do_reset(2);
    cycle(1, 0, 0, 32'h0, 1);
    check("late_pc", pc_out, RESET_PC);
    check("late_valid", {31'b0, if_id_valid}, 32'h0);
    run_free(10);

    // random mix of stalls, redirects and latencies
    for (int i = 0; i < 4000; i++) begin
      bit st, rd;
      logic [31:0] t;
      lat = $urandom_range(1, 4);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      t   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                        : ($urandom & 32'h0000_0FFF);
      cycle(1, st, rd, t, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
